// File: rtl/video_out_adapter.sv
// Core-to-scaler video output stage: sync edge pulses, CE stretch, colour expansion,
// scanline dimming and a PIPE-deep pixel path, plus live active-width/height measurement.
module video_out_adapter #(
   parameter int COLOR_BITS = 4,
   parameter int CE_STRETCH = 2,
   parameter int PIPE       = 2,
   parameter int SYNC_POS   = 1,
   parameter int MEAS_BITS  = 12
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ce_pixel,
   input  logic [COLOR_BITS-1:0] r,
   input  logic [COLOR_BITS-1:0] g,
   input  logic [COLOR_BITS-1:0] b,
   input  logic                  hblank,
   input  logic                  vblank,
   input  logic                  hsync,
   input  logic                  vsync,
   input  logic                  scanline_en,
   output logic [23:0]           vid_rgb,
   output logic                  vid_de,
   output logic                  vid_skip,
   output logic                  vid_hs,
   output logic                  vid_vs,
   output logic [MEAS_BITS-1:0]  active_width,
   output logic [MEAS_BITS-1:0]  active_height,
   output logic                  frame_toggle
);

   localparam logic SYNC_IDLE = (SYNC_POS == 0);
   // Bits of history that extend a CE pulse; empty when CE_STRETCH is 1.
   localparam logic [CE_STRETCH-1:0] CE_MASK = CE_STRETCH'((1 << (CE_STRETCH - 1)) - 1);

   function automatic logic [7:0] expand(input logic [COLOR_BITS-1:0] c);
      logic [7:0] e;
      e = '0;
      for (int i = 0; i < 8; i++) e[7-i] = c[COLOR_BITS-1-(i % COLOR_BITS)];
      return e;
   endfunction

   function automatic logic [7:0] dim(input logic [7:0] c, input logic en);
      return en ? {1'b0, c[7:1]} : c;
   endfunction

   function automatic logic [MEAS_BITS-1:0] sat_inc(input logic [MEAS_BITS-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic                  hs_prev_q, vs_prev_q, vid_hs_q, vid_vs_q, line_odd_q, line_odd_d;
   logic [CE_STRETCH-1:0] ce_hist_q;
   logic [PIPE-1:0]       de_pq, skip_pq;
   logic [23:0]           rgb_pq [PIPE];
   logic                  de_out_prev_q, line_seen_q, line_seen_d, toggle_q, toggle_d;
   logic [MEAS_BITS-1:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [MEAS_BITS-1:0]  width_q, width_d, height_q, height_d, v_line;
   logic                  hs_edge, vs_edge, ce_held, de_c, skip_c, dim_en;
   logic                  de_out, pix, de_fall, seen;
   logic [23:0]           rgb_c;

   assign hs_edge = (hsync != SYNC_IDLE) && (hs_prev_q == SYNC_IDLE);
   assign vs_edge = (vsync != SYNC_IDLE) && (vs_prev_q == SYNC_IDLE);
   assign ce_held = ce_pixel | (|(ce_hist_q & CE_MASK));
   assign de_c    = ~(hblank | vblank);
   assign skip_c  = de_c & ~ce_held;
   assign dim_en  = scanline_en & line_odd_q;
   assign rgb_c   = de_c ? {dim(expand(r), dim_en), dim(expand(g), dim_en), dim(expand(b), dim_en)}
                         : 24'd0;

   // Vsync clears parity even if an hsync edge lands in the same cycle.
   assign line_odd_d = vs_edge ? 1'b0 : (hs_edge ? ~line_odd_q : line_odd_q);

   assign de_out  = de_pq[PIPE-1];
   assign pix     = de_out & ~skip_pq[PIPE-1];
   assign de_fall = de_out_prev_q & ~de_out;

   always_comb begin
      h_cnt_d  = h_cnt_q;
      width_d  = width_q;
      height_d = height_q;
      toggle_d = toggle_q;
      v_line   = v_cnt_q;
      seen     = line_seen_q | pix;
      if (pix) begin
         h_cnt_d = sat_inc(h_cnt_q);
      end else if (de_fall && (h_cnt_q != '0)) begin
         width_d = h_cnt_q;
         h_cnt_d = '0;
      end
      if (de_fall && line_seen_q) begin
         v_line = sat_inc(v_cnt_q);
         seen   = 1'b0;
      end
      // A line closing in the same cycle as the frame boundary belongs to the old frame.
      if (vid_vs_q) begin
         height_d = v_line;
         v_cnt_d  = '0;
         toggle_d = ~toggle_q;
      end else begin
         v_cnt_d  = v_line;
      end
      line_seen_d = seen;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hs_prev_q     <= SYNC_IDLE;
         vs_prev_q     <= SYNC_IDLE;
         vid_hs_q      <= 1'b0;
         vid_vs_q      <= 1'b0;
         line_odd_q    <= 1'b0;
         ce_hist_q     <= '0;
         de_pq         <= '0;
         skip_pq       <= '0;
         for (int i = 0; i < PIPE; i++) rgb_pq[i] <= 24'd0;
         de_out_prev_q <= 1'b0;
         line_seen_q   <= 1'b0;
         toggle_q      <= 1'b0;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         width_q       <= '0;
         height_q      <= '0;
      end else begin
         hs_prev_q     <= hsync;
         vs_prev_q     <= vsync;
         vid_hs_q      <= hs_edge;
         vid_vs_q      <= vs_edge;
         line_odd_q    <= line_odd_d;
         ce_hist_q     <= (ce_hist_q << 1) | CE_STRETCH'(ce_pixel);
         de_pq[0]      <= de_c;
         skip_pq[0]    <= skip_c;
         rgb_pq[0]     <= rgb_c;
         for (int i = 1; i < PIPE; i++) begin
            de_pq[i]   <= de_pq[i-1];
            skip_pq[i] <= skip_pq[i-1];
            rgb_pq[i]  <= rgb_pq[i-1];
         end
         de_out_prev_q <= de_out;
         line_seen_q   <= line_seen_d;
         toggle_q      <= toggle_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         width_q       <= width_d;
         height_q      <= height_d;
      end
   end

   assign vid_rgb       = rgb_pq[PIPE-1];
   assign vid_de        = de_pq[PIPE-1];
   assign vid_skip      = skip_pq[PIPE-1];
   assign vid_hs        = vid_hs_q;
   assign vid_vs        = vid_vs_q;
   assign active_width  = width_q;
   assign active_height = height_q;
   assign frame_toggle  = toggle_q;

endmodule
